// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle over WIDTH cycles, then a single sign-fixup cycle that writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend sign)
    logic zero;    // divisor was zero
  } ctx_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  ctx_t             ctx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] dvd_raw;

  // operand magnitudes; sign flags only for the signed ops
  logic             is_signed, s1_neg, s2_neg;
  logic [WIDTH-1:0] s1_mag, s2_mag;

  assign is_signed = ~i_op[0];
  assign s1_neg    = is_signed & i_src1[WIDTH-1];
  assign s2_neg    = is_signed & i_src2[WIDTH-1];
  assign s1_mag    = s1_neg ? -i_src1 : i_src1;
  assign s2_mag    = s2_neg ? -i_src2 : i_src2;

  // multiply step: {acc_hi,acc_lo} holds partial product and remaining multiplier
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign sum       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = sum[WIDTH:1];
  assign mul_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};

  // restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out, quotient in
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff, div_hi_nx, div_lo_nx;
  logic             fits;

  assign r_sh      = {acc_hi, acc_lo[WIDTH-1]};
  assign fits      = (r_sh >= {1'b0, mcand});
  assign diff      = r_sh[WIDTH-1:0] - mcand;
  assign div_hi_nx = fits ? diff : r_sh[WIDTH-1:0];
  assign div_lo_nx = {acc_lo[WIDTH-2:0], fits};

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = ctx.neg_q ? -prod : prod;
  assign quo_s  = ctx.neg_q ? -acc_lo : acc_lo;
  assign rem_s  = ctx.neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ctx           <= '0;
      mcand         <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      dvd_raw       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            ctx.is_div <= i_op[1];
            ctx.neg_q  <= s1_neg ^ s2_neg;
            ctx.neg_r  <= s1_neg;
            ctx.zero   <= (i_src2 == '0);
            mcand      <= i_op[1] ? s2_mag : s1_mag;
            acc_lo     <= i_op[1] ? s1_mag : s2_mag;
            acc_hi     <= '0;
            dvd_raw    <= i_src1;
            cnt        <= '0;
            o_busy     <= 1'b1;
            state      <= RUN;
          end else begin
            if (i_mthi) o_hi <= i_src1;
            if (i_mtlo) o_lo <= i_src1;
          end
        end
        RUN: begin
          if (ctx.is_div) begin
            acc_hi <= div_hi_nx;
            acc_lo <= div_lo_nx;
          end else begin
            acc_hi <= mul_hi_nx;
            acc_lo <= mul_lo_nx;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!ctx.is_div) begin
            o_hi <= prod_s[2*WIDTH-1:WIDTH];
            o_lo <= prod_s[WIDTH-1:0];
          end else if (ctx.zero) begin
            o_hi <= dvd_raw;
            o_lo <= '1;
          end else begin
            o_hi <= rem_s;
            o_lo <= quo_s;
          end
          o_div_by_zero <= ctx.is_div & ctx.zero;
          o_done        <= 1'b1;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, busy window,
// busy-time input masking, mthi/mtlo writes and reset abort.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_src1(src1), .i_src2(src2), .i_mthi(mthi), .i_mtlo(mtlo),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_div_by_zero(dbz)
  );

  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // lat = index of the rising edge (after the start edge) at which o_done is first
  // seen high, sampled on the preceding falling edge; bcyc = sampled busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    lat = 0; bcyc = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      start = 1'b0; mthi = 1'b0;
      if (inject && lat == 10) begin
        start = 1'b1; mthi = 1'b1; op = ~o; src1 = 32'h5555_5555; src2 = 32'h3;
      end
      if (busy) bcyc++;
      if (done) break;
    end
    start = 1'b0; mthi = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  int  lat, bcyc;
  bit  seen;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcyc);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    check("latency", lat, 32'd34);
    check("busy_cycles", bcyc, 32'd33);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_pulse_1cyc", {31'd0, done}, 32'd0);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bcyc);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);

    run_op(MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bcyc);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0000_0000);

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcyc);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(DIVU, 32'd100, 32'd7, 1'b0, lat, bcyc);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_dbz", {31'd0, dbz}, 32'd0);

    run_op(DIVU, 32'h1234, 32'd0, 1'b0, lat, bcyc);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234);
    check("div0_dbz", {31'd0, dbz}, 32'd1);
    check("div0_latency", lat, 32'd34);

    run_op(MULTU, 32'd2, 32'd3, 1'b0, lat, bcyc);
    check("mul_clr_dbz", {31'd0, dbz}, 32'd0);
    check("mul_small_lo", lo, 32'd6);

    run_op(DIVU, 32'd100, 32'd7, 1'b1, lat, bcyc);
    check("inject_lo", lo, 32'd14);
    check("inject_hi", hi, 32'd2);
    check("inject_latency", lat, 32'd34);
    @(negedge clk);
    check("inject_no_restart", {31'd0, busy}, 32'd0);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; src1 = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mtlo_lo", lo, 32'hA5A5_A5A5);
    check("mt_no_done", {31'd0, done}, 32'd0);
    check("mt_no_busy", {31'd0, busy}, 32'd0);

    run_op(DIVU, 32'h1234, 32'd0, 1'b0, lat, bcyc);
    check("div0b_dbz", {31'd0, dbz}, 32'd1);

    // reset 10 cycles into a DIV: everything clears asynchronously and no result appears
    @(negedge clk);
    start = 1'b1; op = DIV; src1 = 32'd1000; src2 = 32'd3;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    run_op(MULTU, 32'd5, 32'd5, 1'b0, lat, bcyc);
    check("post_rst_lo", lo, 32'd25);
    check("post_rst_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, giving operand and HI/LO width.
REQ-002 SHALL provide i_clk  input  1  single rising-edge clock.
REQ-003 SHALL provide i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide i_start  input  1  request to begin an operation, sampled on i_clk rising edge.
REQ-005 SHALL provide i_op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL provide i_src1  input  WIDTH  multiplicand or dividend; data for i_mthi and i_mtlo.
REQ-007 SHALL provide i_src2  input  WIDTH  multiplier or divisor.
REQ-008 SHALL provide i_mthi  input  1  write i_src1 into HI.
REQ-009 SHALL provide i_mtlo  input  1  write i_src1 into LO.
REQ-010 SHALL provide o_busy  output  1  operation in progress; pipeline stall for HI/LO consumers.
REQ-011 SHALL provide o_done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-012 SHALL provide o_hi  output  WIDTH  HI register.
REQ-013 SHALL provide o_lo  output  WIDTH  LO register.
REQ-014 SHALL provide o_div_by_zero  output  1  last completed DIV/DIVU had divisor 0.

Function
REQ-015 SHALL implement three states, IDLE, RUN and FIX, with a WIDTH-step iteration counter.
REQ-016 IDLE with i_start=1 at edge k SHALL latch the operands as magnitudes, with sign flags for MULT/DIV only, and enter RUN.
REQ-017 RUN SHALL perform one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle for exactly WIDTH cycles, then enter FIX.
REQ-018 FIX SHALL apply sign correction, write HI/LO, pulse o_done for one cycle and return to IDLE; HI/LO SHALL be valid after edge k+WIDTH+2.
REQ-019 o_busy SHALL be 1 in RUN and FIX and 0 in IDLE, including the o_done cycle.
REQ-020 MULT/MULTU SHALL write the 2*WIDTH product: upper half to HI, lower half to LO.
REQ-021 MULT SHALL negate the product when exactly one operand is negative; MULTU SHALL treat both operands as unsigned.
REQ-022 DIV/DIVU SHALL write the quotient to LO and the remainder to HI.
REQ-023 DIV SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-024 DIV with dividend -2^(WIDTH-1) and divisor -1 SHALL give LO=0x80000000 and HI=0 (WIDTH=32), with no overflow flag.
REQ-025 Divisor 0 SHALL still take the full latency, then give LO=all ones, HI=dividend as supplied, and o_div_by_zero=1.
REQ-026 o_div_by_zero SHALL be updated only in FIX of DIV/DIVU and cleared in FIX of MULT/MULTU.
REQ-027 i_start, i_mthi and i_mtlo SHALL be ignored while o_busy=1.
REQ-028 In IDLE, i_start SHALL take priority over i_mthi/i_mtlo, which are then ignored.
REQ-029 In IDLE without i_start, i_mthi and i_mtlo SHALL write HI/LO at the edge, and asserting both SHALL write both.
REQ-030 i_mthi/i_mtlo SHALL NOT pulse o_done.
REQ-031 i_op SHALL be sampled only with i_start; operand changes during RUN SHALL NOT affect the result.
REQ-032 HI/LO SHALL hold their value during RUN and change only in FIX or on i_mthi/i_mtlo.

Reset
REQ-033 i_rst=1 SHALL immediately force IDLE, counter 0, o_busy=0, o_done=0, o_hi=0, o_lo=0 and o_div_by_zero=0.
REQ-034 Reset during RUN or FIX SHALL abort the operation with no HI/LO update and no o_done pulse.
REQ-035 The first i_start after reset release SHALL be accepted normally.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_done exactly 34 cycles after the start edge; o_busy high 33 cycles.
REQ-037 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-038 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-039 DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, o_div_by_zero=1; a following MULTU 2 x 3 -> o_div_by_zero=0, LO=6.
REQ-040 i_start and i_mthi pulsed mid-RUN -> both ignored, result unchanged; in IDLE, i_mthi+i_mtlo with i_src1=0xA5A5A5A5 -> HI=LO=0xA5A5A5A5 and no o_done.
REQ-041 i_rst pulsed 10 cycles into DIV -> all outputs 0 at once, no o_done; a new MULTU 5 x 5 afterwards -> LO=25.
